// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg: shared control codes for the core (ALU ops, RV32M funct3, mul/div FSM states).
// Contents: alu_ctrl_e, func_e (funct3), state_e, CNT_W, and a_signed/b_signed, which
// say which operands a funct3 code treats as signed.
package mul_div_unit_pkg;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
   } alu_ctrl_e;

   typedef enum logic [2:0] {
      F_MUL    = 3'b000,
      F_MULH   = 3'b001,
      F_MULHSU = 3'b010,
      F_MULHU  = 3'b011,
      F_DIV    = 3'b100,
      F_DIVU   = 3'b101,
      F_REM    = 3'b110,
      F_REMU   = 3'b111
   } func_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_BUSY = 2'b01,
      S_DONE = 2'b10
   } state_e;

   localparam int CNT_W = 6;

   function automatic logic a_signed(input logic [2:0] f);
      return f inside {F_MULH, F_MULHSU, F_DIV, F_REM};
   endfunction

   function automatic logic b_signed(input logic [2:0] f);
      return f inside {F_MULH, F_DIV, F_REM};
   endfunction

endpackage

// File: rtl/mul_div_iter.sv
// mul_div_iter: unsigned iterative datapath, one radix-2 step per cycle.
// Ports: clk, rst (sync, active-high); load latches a/b/is_div; step performs one
// iteration; hi/lo form the 2*DWIDTH accumulator.
// Multiply: {hi,lo} = a*b after DWIDTH steps. Divide: lo = quotient, hi = remainder.
module mul_div_iter #(
   parameter int DWIDTH = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              step,
   input  logic              is_div,
   input  logic [DWIDTH-1:0] a,
   input  logic [DWIDTH-1:0] b,
   output logic [DWIDTH-1:0] hi,
   output logic [DWIDTH-1:0] lo
);
   logic [DWIDTH-1:0] bq;
   logic              div_mode;
   logic [DWIDTH:0]   sum, sh, diff;
   logic              ge;
   // Multiply adds b into hi when the multiplier LSB is set, then shifts right;
   // divide shifts {hi,lo} left and keeps the trial subtraction only when it fits.
   always_comb begin
      sum  = {1'b0, hi} + (lo[0] ? {1'b0, bq} : '0);
      sh   = {hi, lo[DWIDTH-1]};
      ge   = sh >= {1'b0, bq};
      diff = sh - {1'b0, bq};
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         hi       <= '0;
         lo       <= '0;
         bq       <= '0;
         div_mode <= 1'b0;
      end else if (load) begin
         hi       <= '0;
         lo       <= a;
         bq       <= b;
         div_mode <= is_div;
      end else if (step) begin
         hi <= div_mode ? (ge ? diff[DWIDTH-1:0] : sh[DWIDTH-1:0]) : sum[DWIDTH:1];
         lo <= div_mode ? {lo[DWIDTH-2:0], ge} : {sum[0], lo[DWIDTH-1:1]};
      end
   end
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: RV32M multiply/divide unit with a fixed 33-cycle latency.
// Ports: clk, rst (sync, active-high); A, B, func, in_valid/in_ready request side;
// kill flushes an in-flight op; out, out_valid/out_ready result side.
// Operands are reduced to magnitudes at accept, and the result sign is applied
// on the cycle after the last iteration.
module mul_div_unit
   import mul_div_unit_pkg::*;
#(
   parameter int DWIDTH = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DWIDTH-1:0] A,
   input  logic [DWIDTH-1:0] B,
   input  logic [2:0]        func,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              kill,
   output logic [DWIDTH-1:0] out,
   output logic              out_valid,
   input  logic              out_ready
);
   state_e              state, state_nx;
   logic [CNT_W-1:0]    cnt;
   logic [2:0]          op;
   logic                neg, neg_in, sa, sb, accept, step, last;
   logic [DWIDTH-1:0]   a_mag, b_mag, hi, lo, dv, dv_fix, res;
   logic [2*DWIDTH-1:0] prod, prod_fix;
   always_comb begin
      in_ready  = state == S_IDLE;
      out_valid = state == S_DONE;
      accept    = in_valid & in_ready & ~kill;
      step      = state == S_BUSY && cnt < CNT_W'(DWIDTH);
      last      = state == S_BUSY && cnt == CNT_W'(DWIDTH);
      sa        = a_signed(func) & A[DWIDTH-1];
      sb        = b_signed(func) & B[DWIDTH-1];
      a_mag     = sa ? -A : A;
      b_mag     = sb ? -B : B;
      // Remainder takes the dividend sign; a zero divisor leaves the all-ones quotient unsigned.
      neg_in    = func[2] ? (func[1] ? sa : (sa ^ sb) & (|B)) : sa ^ sb;
   end
   always_comb begin
      state_nx = (state != S_IDLE && kill)       ? S_IDLE :
                 (state == S_IDLE && accept)     ? S_BUSY :
                 last                            ? S_DONE :
                 (state == S_DONE && out_ready)  ? S_IDLE : state;
   end
   always_ff @(posedge clk) begin
      state <= rst ? S_IDLE : state_nx;
   end
   always_comb begin
      prod     = {hi, lo};
      prod_fix = neg ? -prod : prod;
      dv       = op[1] ? hi : lo;
      dv_fix   = neg ? -dv : dv;
      res      = op[2] ? dv_fix :
                 (op[1:0] == 2'b00) ? prod_fix[DWIDTH-1:0] : prod_fix[2*DWIDTH-1:DWIDTH];
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         op  <= '0;
         neg <= 1'b0;
         out <= '0;
      end else begin
         if (accept) begin
            cnt <= '0;
            op  <= func;
            neg <= neg_in;
         end else if (step) begin
            cnt <= cnt + 1'b1;
         end
         if (last) out <= res;
      end
   end
   mul_div_iter #(.DWIDTH(DWIDTH)) u_iter (
      .clk    (clk),
      .rst    (rst),
      .load   (accept),
      .step   (step),
      .is_div (func[2]),
      .a      (a_mag),
      .b      (b_mag),
      .hi     (hi),
      .lo     (lo)
   );
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: randomized self-checking bench for mul_div_unit against an arithmetic model.
module tb_mul_div_unit;
   logic        clk = 1'b0;
   logic        rst, in_valid, kill, out_ready, in_ready, out_valid;
   logic [31:0] a, b, dout;
   logic [2:0]  func;
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   mul_div_unit #(.DWIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .A         (a),
      .B         (b),
      .func      (func),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .kill      (kill),
      .out       (dout),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
      longint      sx, sy, ux, uy;
      logic [63:0] p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = longint'({32'h0, x});
      uy = longint'({32'h0, y});
      case (f)
         3'd0:    begin p = 64'(ux * uy); return p[31:0];  end
         3'd1:    begin p = 64'(sx * sy); return p[63:32]; end
         3'd2:    begin p = 64'(sx * uy); return p[63:32]; end
         3'd3:    begin p = 64'(ux * uy); return p[63:32]; end
         3'd4:    begin if (y == 0) return '1; p = 64'(sx / sy); return p[31:0]; end
         3'd5:    return (y == 0) ? '1 : x / y;
         3'd6:    begin if (y == 0) return x; p = 64'(sx % sy); return p[31:0]; end
         default: return (y == 0) ? x : x % y;
      endcase
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 9));
         default: return 32'($urandom);
      endcase
   endfunction

   // Entered and left at #1 after a rising edge with the unit idle.
   task automatic run_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y, input int hold);
      int          lat;
      logic [31:0] exp_v, held;
      lat   = 0;
      exp_v = model(f, x, y);
      func = f; a = x; b = y; in_valid = 1'b1;
      check("idle_rdy", {63'd0, in_ready}, 64'd1);
      @(posedge clk); #1;
      check("busy_rdy", {63'd0, in_ready}, 64'd0);
      in_valid = 1'($urandom); a = $urandom; b = $urandom; func = 3'($urandom);
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      in_valid = 1'b0;
      check("latency", 64'(lat), 64'd33);
      check($sformatf("result f=%0d a=%h b=%h", f, x, y), {32'd0, dout}, {32'd0, exp_v});
      held = dout;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check("hold_out", {32'd0, dout}, {32'd0, held});
         check("hold_flags", {62'd0, in_ready, out_valid}, 64'b01);
      end
      out_ready = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b0;
      check("consume_flags", {62'd0, in_ready, out_valid}, 64'b10);
   endtask

   task automatic abort_test(input bit use_rst, input bit in_done);
      logic seen;
      func = 3'd4; a = 32'd100; b = 32'd7; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (in_done ? 35 : 10) begin @(posedge clk); #1; end
      if (in_done) check("pre_abort_valid", {63'd0, out_valid}, 64'd1);
      if (use_rst) rst = 1'b1; else kill = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; kill = 1'b0;
      check("abort_flags", {62'd0, in_ready, out_valid}, 64'b10);
      if (use_rst) begin
         check("rst_out", {32'd0, dout}, 64'd0);
         check("rst_cnt", {58'd0, dut.cnt}, 64'd0);
         check("rst_acc", {dut.u_iter.hi, dut.u_iter.lo}, 64'd0);
      end
      seen = 1'b0;
      repeat (40) begin @(posedge clk); #1; seen |= out_valid; end
      check("no_valid_after_abort", {63'd0, seen}, 64'd0);
   endtask

   initial begin
      rst = 1'b1; kill = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
      a = 32'd3; b = 32'd4; func = 3'd0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_flags", {62'd0, in_ready, out_valid}, 64'b10);
      check("reset_out", {32'd0, dout}, 64'd0);
      check("reset_cnt", {58'd0, dut.cnt}, 64'd0);
      check("reset_acc", {dut.u_iter.hi, dut.u_iter.lo}, 64'd0);
      rst = 1'b0; in_valid = 1'b0;

      run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
      run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
      run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
      run_op(3'd5, 32'd5, 32'd0, 0);
      run_op(3'd7, 32'd5, 32'd0, 0);
      run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op(3'd4, 32'hFFFF_FFF9, 32'd0, 0);
      run_op(3'd6, 32'hFFFF_FFF9, 32'd0, 0);
      run_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5);

      kill = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      kill = 1'b0; in_valid = 1'b0;
      check("kill_idle_no_accept", {63'd0, in_ready}, 64'd1);
      rst = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      check("rst_no_accept", {63'd0, in_ready}, 64'd1);

      abort_test(1'b0, 1'b0);
      run_op(3'd4, 32'hFFFF_FF9C, 32'd7, 0);
      abort_test(1'b1, 1'b0);
      run_op(3'd6, 32'hFFFF_FF9C, 32'd7, 0);
      abort_test(1'b0, 1'b1);
      abort_test(1'b1, 1'b1);

      for (int i = 0; i < 150; i++) run_op(3'($urandom), pick(), pick(), $urandom_range(0, 2));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
